program_loader: RTL and testbench
=================================

# program_loader

Byte-stream program loader that sits directly upstream of the CPU's load port. It accepts a framed byte stream over a valid/ready handshake and writes instruction bytes into the Instruction Register and data bytes into the Data Register through the CPU's `load` / `is_instruction` / `load_address` / `cpu_input` interface. It holds the CPU in reset until a complete frame with a correct checksum has been written.

## Interface

**Parameters**
- `HEADER`, default 8'hA5: frame start byte.
- `MAX_INSTR`, default 32: maximum instruction byte count, sized to the 5-bit instruction address space.
- `MAX_DATA`, default 16: maximum data byte count, sized to the 4-bit data address space.

**Ports**
- `clk`  in  1: single clock for all logic.
- `reset`  in  1: asynchronous, active-low reset.
- `in_data`  in  8: stream byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader can accept a byte; a byte transfers when `in_valid && in_ready` at a rising edge.
- `cpu_input`  out  8: byte to the CPU load port.
- `load_address`  out  5: target address; bit 4 is always 0 for data bytes.
- `load`  out  1: one-cycle write strobe to the CPU.
- `is_instruction`  out  1: 1 selects instruction memory, 0 selects data memory.
- `cpu_hold`  out  1: drives the CPU's active-high `reset`.
- `done`  out  1: last frame loaded with a good checksum.
- `error`  out  1: last frame was aborted or failed its checksum.

## Operation

**Frame format:** `HEADER`, N, N instruction bytes, M, M data bytes, CHK.
- Legal counts: N in 1..`MAX_INSTR`; M in 0..`MAX_DATA`.
- CHK is the 8-bit sum, mod 256, of N, M and all payload bytes.

**FSM states:** HUNT, ICNT, INSTR, DCNT, DATA, CHECK, DONE, ERROR.
- **HUNT, DONE, ERROR**
  - Accept and discard bytes.
  - An accepted `HEADER` byte goes to ICNT. In the same cycle it clears `done` and `error`, sets `cpu_hold`, and clears the checksum and index.
- **ICNT**
  - A byte of 0 or greater than `MAX_INSTR` goes to ERROR.
  - Otherwise latch N, add it to the sum, and go to INSTR.
- **INSTR**
  - Each accepted byte issues an instruction write at address idx, adds to the sum, and increments idx.
  - After the N-th byte, clear idx and go to DCNT.
- **DCNT**
  - A byte greater than `MAX_DATA` goes to ERROR.
  - M = 0 goes straight to CHECK.
  - Otherwise latch M, add it to the sum, and go to DATA.
- **DATA**
  - Same as INSTR, but with `is_instruction` = 0 and addresses 0..M-1.
  - After the M-th byte, go to CHECK.
- **CHECK**
  - If the accepted byte equals the sum, go to DONE: set `done` and clear `cpu_hold`.
  - Otherwise go to ERROR: set `error`; `cpu_hold` stays 1.

**Behaviour rules**
- `HEADER` bytes inside a frame are ordinary payload bytes; there is no resynchronisation mid-frame.
- Writes already issued are not undone on error. `cpu_hold` = 1 keeps the CPU from executing partial contents.
- `in_ready` is 1 in every state once out of reset. The loader never back-pressures.
- `done` and `error` are never both 1 at the same time.

## Timing

**Reset values (while `reset` = 0):**
- `cpu_hold` = 1, `in_ready` = 0.
- `load`, `is_instruction`, `load_address`, `cpu_input`, `done`, `error` are all 0.
- FSM is in HUNT.

**Registered outputs and latency:**
- A payload byte accepted at edge t gives `load` = 1 with its `cpu_input`, `load_address` and `is_instruction` for exactly the cycle following edge t. `load` = 0 otherwise.
- Back-to-back accepted bytes produce back-to-back `load` pulses; the maximum rate is one write per cycle.
- The CHECK byte accepted at edge t gives `done` = 1 and `cpu_hold` = 0 after edge t. The CPU leaves reset on the following edge.
- Idle cycles (`in_valid` = 0) pause the frame indefinitely. There is no timeout.

**Reset and overflow:**
- Reset asserted mid-frame aborts immediately: the FSM returns to HUNT, `load` drops, and `cpu_hold` = 1.
- idx and counts are 6 bits wide so that `MAX_INSTR` = 32 needs no wrap. Address outputs are truncated to 5 bits.

## Structure

- Shared package `cpu_loader_pkg` holds:
  - the state enum type;
  - the `HEADER`, `MAX_INSTR` and `MAX_DATA` default constants;
  - the instruction and data address width constants (5 and 4). The CPU top level also uses these.
- Single flat module, with no sub-module. The checksum is one 8-bit adder register inside the module.

## Test plan

- **Good frame:** stream A5, 02, 11, 22, 01, 33, 69 with no gaps.
  - Expect instruction writes 0:11 and 1:22, then data write 0:33, on consecutive cycles.
  - Expect `done` = 1 and `cpu_hold` = 0 after the final byte.
- **Bad checksum:** same frame with CHK = 68.
  - Expect the same three writes, then `error` = 1 and `cpu_hold` = 1.
  - A following good frame must end with `done` = 1 and `error` = 0.
- **Illegal counts:** N = 00, then separately N = 21 (hex 21 = 33), then M = 11 (hex 11 = 17).
  - Expect `error` = 1 immediately after the count byte, no `load` pulses, and further bytes ignored until A5.
- **Maximum-size frame and idle gaps:** N = 32, M = 16, with `in_valid` dropped for 3 random cycles between bytes.
  - Expect instruction addresses 0..31 and data addresses 0..15 in order, and `done` = 1.
- **Reset mid-frame:** assert `reset` = 0 for 1 cycle after the 3rd payload byte.
  - Expect all outputs at their reset values and FSM in HUNT.
  - A subsequent good frame must load correctly.
- **Stray bytes before header:** send 00, FF, 5A, then a good frame.
  - Expect no `load` pulse before the A5 header, then a normal load ending with `done` = 1.

Source files
------------

// File: rtl/cpu_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader_pkg
// Description : Shared types and constants for the CPU program loader and the
//               CPU top level. Holds the loader state encoding, the default
//               frame constants and the instruction/data address widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_loader_pkg;

   // Default frame constants
   localparam logic [7:0] DEF_HEADER    = 8'hA5;
   localparam int         DEF_MAX_INSTR = 32;
   localparam int         DEF_MAX_DATA  = 16;

   // CPU memory address widths
   localparam int INSTR_ADDR_W = 5;
   localparam int DATA_ADDR_W  = 4;

   // Index/count width: one bit wider than the instruction address so that a
   // full 32-byte instruction section can be counted without wrapping.
   localparam int IDX_W = INSTR_ADDR_W + 1;

   typedef enum logic [2:0] {
      HUNT  = 3'd0,
      ICNT  = 3'd1,
      INSTR = 3'd2,
      DCNT  = 3'd3,
      DATA  = 3'd4,
      CHECK = 3'd5,
      DONE  = 3'd6,
      ERROR = 3'd7
   } state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Byte-stream program loader. Parses frames of the form
//               HEADER, N, N instruction bytes, M, M data bytes, CHK and
//               writes the payload into the CPU through its load port. The
//               CPU is held in reset until a frame with a good checksum has
//               been completely written.
// Ports       : clk            - clock
//               reset          - asynchronous reset, active low
//               in_data        - stream byte
//               in_valid       - in_data is valid
//               in_ready       - loader accepts a byte (1 whenever out of reset)
//               cpu_input      - byte to the CPU load port
//               load_address   - CPU load address (bit 4 = 0 for data bytes)
//               load           - one-cycle write strobe
//               is_instruction - 1 = instruction memory, 0 = data memory
//               cpu_hold       - drives the CPU's active-high reset
//               done           - last frame loaded with a good checksum
//               error          - last frame aborted or failed its checksum
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
   import cpu_loader_pkg::*;
#(
   parameter logic [7:0] HEADER    = DEF_HEADER,
   parameter int         MAX_INSTR = DEF_MAX_INSTR,
   parameter int         MAX_DATA  = DEF_MAX_DATA
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [7:0]              cpu_input,
   output logic [INSTR_ADDR_W-1:0] load_address,
   output logic                    load,
   output logic                    is_instruction,
   output logic                    cpu_hold,
   output logic                    done,
   output logic                    error
);

   localparam logic [7:0] MAX_I = 8'(MAX_INSTR);
   localparam logic [7:0] MAX_D = 8'(MAX_DATA);

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        idx, idx_nxt;
   logic [IDX_W-1:0]        cnt, cnt_nxt;
   logic [7:0]              sum, sum_nxt;
   logic [7:0]              cpu_input_nxt;
   logic [INSTR_ADDR_W-1:0] load_address_nxt;
   logic                    load_nxt;
   logic                    is_instruction_nxt;
   logic                    cpu_hold_nxt;
   logic                    done_nxt;
   logic                    error_nxt;

   logic                    accept;
   logic [IDX_W-1:0]        idx_inc;
   logic                    last_byte;

   assign accept    = in_valid & in_ready;
   assign idx_inc   = idx + IDX_W'(1);
   assign last_byte = (idx_inc == cnt);

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= HUNT;
         idx            <= '0;
         cnt            <= '0;
         sum            <= '0;
         cpu_input      <= '0;
         load_address   <= '0;
         load           <= 1'b0;
         is_instruction <= 1'b0;
         cpu_hold       <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
         in_ready       <= 1'b0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         cnt            <= cnt_nxt;
         sum            <= sum_nxt;
         cpu_input      <= cpu_input_nxt;
         load_address   <= load_address_nxt;
         load           <= load_nxt;
         is_instruction <= is_instruction_nxt;
         cpu_hold       <= cpu_hold_nxt;
         done           <= done_nxt;
         error          <= error_nxt;
         // The loader never back-pressures once out of reset.
         in_ready       <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt          = state;
      idx_nxt            = idx;
      cnt_nxt            = cnt;
      sum_nxt            = sum;
      cpu_input_nxt      = cpu_input;
      load_address_nxt   = load_address;
      load_nxt           = 1'b0;
      is_instruction_nxt = is_instruction;
      cpu_hold_nxt       = cpu_hold;
      done_nxt           = done;
      error_nxt          = error;

      if (accept) begin
         case (state)
            HUNT, DONE, ERROR: begin
               if (in_data == HEADER) begin
                  state_nxt    = ICNT;
                  done_nxt     = 1'b0;
                  error_nxt    = 1'b0;
                  cpu_hold_nxt = 1'b1;
                  sum_nxt      = '0;
                  idx_nxt      = '0;
               end
            end

            ICNT: begin
               if ((in_data == 8'd0) || (in_data > MAX_I)) begin
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
               end else begin
                  cnt_nxt   = in_data[IDX_W-1:0];
                  sum_nxt   = sum + in_data;
                  state_nxt = INSTR;
               end
            end

            INSTR: begin
               load_nxt           = 1'b1;
               is_instruction_nxt = 1'b1;
               load_address_nxt   = idx[INSTR_ADDR_W-1:0];
               cpu_input_nxt      = in_data;
               sum_nxt            = sum + in_data;
               if (last_byte) begin
                  idx_nxt   = '0;
                  state_nxt = DCNT;
               end else begin
                  idx_nxt = idx_inc;
               end
            end

            DCNT: begin
               if (in_data > MAX_D) begin
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
               end else if (in_data == 8'd0) begin
                  state_nxt = CHECK;
               end else begin
                  cnt_nxt   = in_data[IDX_W-1:0];
                  sum_nxt   = sum + in_data;
                  state_nxt = DATA;
               end
            end

            DATA: begin
               load_nxt           = 1'b1;
               is_instruction_nxt = 1'b0;
               // Data memory is narrower; upper address bits are forced to 0.
               load_address_nxt   = {{(INSTR_ADDR_W-DATA_ADDR_W){1'b0}},
                                     idx[DATA_ADDR_W-1:0]};
               cpu_input_nxt      = in_data;
               sum_nxt            = sum + in_data;
               if (last_byte) begin
                  idx_nxt   = '0;
                  state_nxt = CHECK;
               end else begin
                  idx_nxt = idx_inc;
               end
            end

            CHECK: begin
               if (in_data == sum) begin
                  state_nxt    = DONE;
                  done_nxt     = 1'b1;
                  cpu_hold_nxt = 1'b0;
               end else begin
                  // cpu_hold stays asserted so a partial image never runs.
                  state_nxt = ERROR;
                  error_nxt = 1'b1;
               end
            end

            default: state_nxt = HUNT;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. Frame descriptions
//               are kept in a table; expected CPU writes go into a queue as
//               bytes are driven and are compared when load pulses appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

   logic       clk;
   logic       reset;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] cpu_input;
   logic [4:0] load_address;
   logic       load;
   logic       is_instruction;
   logic       cpu_hold;
   logic       done;
   logic       error;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       isi;
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t exp_q[$];

   typedef struct {
      int n;
      int m;
      bit bad_chk;
      int gap_max;
      bit exp_done;
      bit exp_error;
   } vec_t;

   vec_t vecs[9];

   program_loader dut (
      .clk            (clk),
      .reset          (reset),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .cpu_input      (cpu_input),
      .load_address   (load_address),
      .load           (load),
      .is_instruction (is_instruction),
      .cpu_hold       (cpu_hold),
      .done           (done),
      .error          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every load pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (load === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_load: got addr %h data %h isi %b expected no write",
                     load_address, cpu_input, is_instruction);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("load_write", {18'd0, is_instruction, load_address, cpu_input}, {18'd0, e});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int gap(input int mx);
      if (mx == 0) return 0;
      return int'($urandom_range(0, mx));
   endfunction

   // Called at posedge+1; returns at posedge+1 after the byte transferred.
   task automatic send_byte(input logic [7:0] b, input int g);
      in_valid = 1'b0;
      repeat (g) begin
         @(posedge clk);
         #1;
      end
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_junk();
      send_byte(8'h00, 0);
      send_byte(8'h5A, 1);
      send_byte(8'hFF, 0);
   endtask

   task automatic run_frame(input vec_t v);
      logic [7:0] sum;
      logic [7:0] b;
      bit         aborted;
      sum     = 8'h00;
      aborted = 1'b0;
      send_byte(8'hA5, gap(v.gap_max));
      send_byte(8'(v.n), gap(v.gap_max));
      if (v.n == 0 || v.n > 32) begin
         check("icnt_error", {31'd0, error}, 32'd1);
         send_junk();
         aborted = 1'b1;
      end else begin
         sum = sum + 8'(v.n);
         for (int i = 0; i < v.n; i++) begin
            b = 8'($urandom);
            exp_q.push_back({1'b1, 5'(i), b});
            send_byte(b, gap(v.gap_max));
            sum = sum + b;
         end
         send_byte(8'(v.m), gap(v.gap_max));
         if (v.m > 16) begin
            check("dcnt_error", {31'd0, error}, 32'd1);
            send_junk();
            aborted = 1'b1;
         end else begin
            sum = sum + 8'(v.m);
            for (int i = 0; i < v.m; i++) begin
               b = 8'($urandom);
               exp_q.push_back({1'b0, 5'(i), b});
               send_byte(b, gap(v.gap_max));
               sum = sum + b;
            end
            send_byte(v.bad_chk ? sum + 8'd1 : sum, gap(v.gap_max));
         end
      end
      if (aborted) check("abort_flag", 32'd1, {31'd0, v.exp_error});
      check("done", {31'd0, done}, {31'd0, v.exp_done});
      check("error", {31'd0, error}, {31'd0, v.exp_error});
      check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !v.exp_done});
      check("pending_writes", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_outputs"},
            {14'd0, cpu_hold, in_ready, load, is_instruction, load_address, cpu_input, done, error},
            {14'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0});
   endtask

   initial begin
      //          n   m  bad gap done err
      vecs[0] = '{ 2,  1, 0,  0,  1,  0};
      vecs[1] = '{ 2,  1, 1,  0,  0,  1};
      vecs[2] = '{ 1,  0, 0,  1,  1,  0};
      vecs[3] = '{ 0,  0, 0,  0,  0,  1};
      vecs[4] = '{33,  0, 0,  0,  0,  1};
      vecs[5] = '{ 3, 17, 0,  0,  0,  1};
      vecs[6] = '{32, 16, 0,  3,  1,  0};
      vecs[7] = '{ 7,  5, 1,  2,  0,  1};
      vecs[8] = '{ 4, 16, 0,  0,  1,  0};

      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("in_ready", {31'd0, in_ready}, 32'd1);

      // Reference frame with known bytes: A5 02 11 22 01 33 69
      exp_q.push_back({1'b1, 5'd0, 8'h11});
      exp_q.push_back({1'b1, 5'd1, 8'h22});
      exp_q.push_back({1'b0, 5'd0, 8'h33});
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
      send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h33, 0);
      send_byte(8'h69, 0);
      check("ref_done", {30'd0, done, error}, {30'd0, 1'b1, 1'b0});
      check("ref_hold", {31'd0, cpu_hold}, 32'd0);

      // Same frame with a wrong checksum
      exp_q.push_back({1'b1, 5'd0, 8'h11});
      exp_q.push_back({1'b1, 5'd1, 8'h22});
      exp_q.push_back({1'b0, 5'd0, 8'h33});
      send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h11, 0);
      send_byte(8'h22, 0); send_byte(8'h01, 0); send_byte(8'h33, 0);
      send_byte(8'h68, 0);
      check("badchk_flags", {30'd0, done, error}, {30'd0, 1'b0, 1'b1});
      check("badchk_hold", {31'd0, cpu_hold}, 32'd1);

      // Table of frames
      for (int i = 0; i < 9; i++) run_frame(vecs[i]);

      // Reset in the middle of the instruction section
      send_byte(8'hA5, 0);
      send_byte(8'h05, 0);
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({1'b1, 5'(i), 8'(8'h40 + i)});
         send_byte(8'(8'h40 + i), 0);
      end
      @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check_reset_values("midreset");
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("midreset_ready", {31'd0, in_ready}, 32'd1);
      // A non-header byte must not continue the aborted frame.
      send_byte(8'h02, 0);
      send_byte(8'h11, 0);
      run_frame(vecs[0]);

      // Stray bytes before a header
      send_byte(8'h00, 0);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 0);
      check("stray_flags", {30'd0, done, error}, {30'd0, 1'b1, 1'b0});
      run_frame(vecs[8]);

      @(posedge clk);
      #1;
      check("final_queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
